// File: rtl/lbp_histogram_pkg.sv
// lbp_hist_pkg: shared types and helpers for the LBP histogram block.
//   - state_t     : ACCUM / DRAIN / DONE encoding
//   - NUM_BINS    : 59 with LBP_HIST_UNIFORM_EN defined (uniform patterns), else 256 (identity)
//   - BIN_AW      : width of a bin index
//   - is_interior : true when {row,col} is not on the image border
//   - uniform_rank: code -> rank among the 58 uniform codes, 58 for non-uniform codes
// Build macro: LBP_HIST_UNIFORM_EN
package lbp_hist_pkg;

   typedef enum logic [1:0] {
      ST_ACCUM = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

`ifdef LBP_HIST_UNIFORM_EN
   localparam int NUM_BINS = 59;
`else
   localparam int NUM_BINS = 256;
`endif
   localparam int BIN_AW = $clog2(NUM_BINS);

   function automatic logic is_interior(input int row, input int col, input int img_n);
      return (row >= 1) && (row <= img_n - 2) && (col >= 1) && (col <= img_n - 2);
   endfunction

   // Number of 0/1 changes walking once round the 8-bit code.
   function automatic int circ_transitions(input logic [7:0] c);
      return $countones(c ^ {c[0], c[7:1]});
   endfunction

   // The loop collapses to constant comparators: uniformity of each v is static.
   function automatic logic [5:0] uniform_rank(input logic [7:0] code);
      logic [5:0] rank;
      rank = 6'd0;
      if (circ_transitions(code) > 2) return 6'd58;
      for (int v = 0; v < 256; v++) begin
         if ((circ_transitions(v[7:0]) <= 2) && (v[7:0] < code)) rank = rank + 6'd1;
      end
      return rank;
   endfunction

endpackage

// File: rtl/lbp_histogram_if.sv
// lbp_histogram_if: engine result strobe plus histogram drain stream.
//   Engine side : lbp_valid, lbp_addr, lbp_data, finish
//   Drain side  : hist_valid/hist_ready handshake carrying hist_bin, hist_count
//   Status      : hist_done, late_err
//   modport slave  - the histogram block
//   modport master - the engine / downstream consumer
interface lbp_histogram_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 14,
   parameter int CNT_W  = 14
);
   logic              lbp_valid;
   logic [ADDR_W-1:0] lbp_addr;
   logic [DATA_W-1:0] lbp_data;
   logic              finish;
   logic              hist_ready;
   logic              hist_valid;
   logic [7:0]        hist_bin;
   logic [CNT_W-1:0]  hist_count;
   logic              hist_done;
   logic              late_err;

   modport slave (
      input  lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
      output hist_valid, hist_bin, hist_count, hist_done, late_err
   );

   modport master (
      output lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
      input  hist_valid, hist_bin, hist_count, hist_done, late_err
   );
endinterface

// File: rtl/lbp_histogram_uniform_map.sv
// lbp_uniform_map: combinational LBP code -> uniform-pattern bin (0..57 uniform, 58 other).
//   code_i : 8-bit LBP code
//   bin_o  : 6-bit bin index
// Used only when LBP_HIST_UNIFORM_EN is defined.
module lbp_uniform_map
   import lbp_hist_pkg::*;
(
   input  logic [7:0] code_i,
   output logic [5:0] bin_o
);
   assign bin_o = uniform_rank(code_i);
endmodule

// File: rtl/lbp_histogram.sv
// lbp_histogram: histogram of LBP codes, drained bin-by-bin once the engine finishes.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   bus        : lbp_histogram_if.slave (engine strobe in, drain stream out, status)
// Build macro: LBP_HIST_UNIFORM_EN selects the 59-bin uniform map; otherwise 256 bins, identity map.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_ACCUM | counting interior samples; finish moves to DRAIN
// ST_DRAIN | streaming bins 0..NUM_BINS-1, each cleared as it is accepted
// ST_DONE  | drain finished, hist_done held until reset
module lbp_histogram
   import lbp_hist_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 14,
   parameter int IMG_N  = 128,
   parameter int CNT_W  = 14
) (
   input logic             clk,
   input logic             reset,
   lbp_histogram_if.slave  bus
);
   localparam int                HALF_W   = ADDR_W / 2;
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [BIN_AW-1:0] LAST_IDX = BIN_AW'(NUM_BINS - 1);

   state_t             state_q;
   logic [BIN_AW-1:0]  idx_q;
   logic               hist_valid_q;
   logic               hist_done_q;
   logic               late_err_q;
   logic [CNT_W-1:0]   bin_q [NUM_BINS];

   logic [DATA_W-1:0]  code;
   logic [HALF_W-1:0]  row;
   logic [HALF_W-1:0]  col;
   logic [BIN_AW-1:0]  map_bin;
   logic               inc_en;
   logic               xfer;

   assign code = bus.lbp_data;
   assign row  = bus.lbp_addr[ADDR_W-1 -: HALF_W];
   assign col  = bus.lbp_addr[HALF_W-1:0];

`ifdef LBP_HIST_UNIFORM_EN
   lbp_uniform_map u_map (
      .code_i (code),
      .bin_o  (map_bin)
   );
`else
   assign map_bin = code[BIN_AW-1:0];
`endif

   assign inc_en = (state_q == ST_ACCUM) && bus.lbp_valid &&
                   is_interior(int'(row), int'(col), IMG_N);
   assign xfer   = hist_valid_q && bus.hist_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_ACCUM;
         idx_q        <= '0;
         hist_valid_q <= 1'b0;
         hist_done_q  <= 1'b0;
         late_err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_ACCUM: begin
               if (bus.finish) begin
                  state_q      <= ST_DRAIN;
                  hist_valid_q <= 1'b1;
               end
            end
            ST_DRAIN: begin
               if (bus.lbp_valid) late_err_q <= 1'b1;
               if (xfer) begin
                  if (idx_q == LAST_IDX) begin
                     state_q      <= ST_DONE;
                     hist_valid_q <= 1'b0;
                     hist_done_q  <= 1'b1;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               if (bus.lbp_valid) late_err_q <= 1'b1;
            end
            default: state_q <= ST_ACCUM;
         endcase
      end
   end

   // Increment and clear never coincide: one happens only in ACCUM, the other only in DRAIN.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int b = 0; b < NUM_BINS; b++) bin_q[b] <= '0;
      end else begin
         if (inc_en && (bin_q[map_bin] != CNT_MAX)) bin_q[map_bin] <= bin_q[map_bin] + 1'b1;
         if (xfer) bin_q[idx_q] <= '0;
      end
   end

   assign bus.hist_valid = hist_valid_q;
   assign bus.hist_bin   = 8'(idx_q);
   assign bus.hist_count = bin_q[idx_q];
   assign bus.hist_done  = hist_done_q;
   assign bus.late_err   = late_err_q;

endmodule

// File: tb/tb_lbp_histogram.sv
`timescale 1ns/1ps
module tb_lbp_histogram;
   import lbp_hist_pkg::*;

   localparam int NW = 14;
   localparam int NN = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic        s_valid = 1'b0;
   logic [13:0] s_addr  = '0;
   logic [7:0]  s_data  = '0;
   logic        s_finish = 1'b0;
   logic        s_ready  = 1'b0;

   lbp_histogram_if #(.CNT_W(NW)) bw ();
   lbp_histogram_if #(.CNT_W(NN)) bn ();

   assign bw.lbp_valid = s_valid;  assign bn.lbp_valid = s_valid;
   assign bw.lbp_addr  = s_addr;   assign bn.lbp_addr  = s_addr;
   assign bw.lbp_data  = s_data;   assign bn.lbp_data  = s_data;
   assign bw.finish    = s_finish; assign bn.finish    = s_finish;
   assign bw.hist_ready = s_ready; assign bn.hist_ready = s_ready;

   lbp_histogram #(.CNT_W(NW)) dut_w (.clk(clk), .reset(reset), .bus(bw.slave));
   lbp_histogram #(.CNT_W(NN)) dut_n (.clk(clk), .reset(reset), .bus(bn.slave));

   int checks = 0;
   int errors = 0;

   task automatic cmp(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int unsigned m_cnt [256];
   int          m_phase = 0;   // 0 counting, 1 draining, 2 finished
   int          m_idx   = 0;
   bit          m_late  = 1'b0;
   int          uq[$];         // uniform codes, ascending

   function automatic int trans(int c);
      int n = 0;
      for (int i = 0; i < 8; i++)
         if (((c >> i) & 1) != ((c >> ((i + 1) % 8)) & 1)) n++;
      return n;
   endfunction

   function automatic int model_bin(int code);
`ifdef LBP_HIST_UNIFORM_EN
      if (trans(code) > 2) return 58;
      foreach (uq[k]) if (uq[k] == code) return k;
      return -1;
`else
      return code;
`endif
   endfunction

   function automatic bit interior(int a);
      int r = a >> 7;
      int c = a & 127;
      return (r >= 1) && (r <= 126) && (c >= 1) && (c <= 126);
   endfunction

   function automatic int sat(int unsigned v, int w);
      int unsigned mx = (32'd1 << w) - 1;
      return int'((v > mx) ? mx : v);
   endfunction

   initial begin
      for (int c = 0; c < 256; c++) if (trans(c) <= 2) uq.push_back(c);
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int b = 0; b < 256; b++) m_cnt[b] = 0;
         m_phase = 0; m_idx = 0; m_late = 1'b0;
      end else begin
         case (m_phase)
            0: begin
               if (s_valid && interior(int'(s_addr))) m_cnt[model_bin(int'(s_data))]++;
               if (s_finish) begin m_phase = 1; m_idx = 0; end
            end
            1: begin
               if (s_valid) m_late = 1'b1;
               if (s_ready) begin
                  m_cnt[m_idx] = 0;
                  if (m_idx == NUM_BINS - 1) m_phase = 2;
                  else m_idx++;
               end
            end
            default: if (s_valid) m_late = 1'b1;
         endcase
      end
   end

   // ---------------- per-cycle compare ----------------
   int cap_w [256];
   int cap_n [256];
   int beats = 0;

   always @(negedge clk) begin
      cmp("w_valid", int'(bw.hist_valid), int'(m_phase == 1));
      cmp("n_valid", int'(bn.hist_valid), int'(m_phase == 1));
      cmp("w_done",  int'(bw.hist_done),  int'(m_phase == 2));
      cmp("n_done",  int'(bn.hist_done),  int'(m_phase == 2));
      cmp("w_late",  int'(bw.late_err),   int'(m_late));
      cmp("n_late",  int'(bn.late_err),   int'(m_late));
      if (m_phase == 1) begin
         cmp("w_bin",   int'(bw.hist_bin),   m_idx);
         cmp("n_bin",   int'(bn.hist_bin),   m_idx);
         cmp("w_count", int'(bw.hist_count), sat(m_cnt[m_idx], NW));
         cmp("n_count", int'(bn.hist_count), sat(m_cnt[m_idx], NN));
         if (s_ready) begin
            cap_w[m_idx] = int'(bw.hist_count);
            cap_n[m_idx] = int'(bn.hist_count);
            beats++;
         end
      end else if (reset) begin
         cmp("rst_w_bin",   int'(bw.hist_bin),   0);
         cmp("rst_w_count", int'(bw.hist_count), 0);
         cmp("rst_n_count", int'(bn.hist_count), 0);
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(bit v, int d, int r, int c, bit f, bit rdy);
      @(posedge clk); #2;
      s_valid = v; s_data = 8'(d); s_addr = {7'(r), 7'(c)}; s_finish = f; s_ready = rdy;
   endtask

   task automatic clear_caps();
      for (int b = 0; b < 256; b++) begin cap_w[b] = -1; cap_n[b] = -1; end
      beats = 0;
   endtask

   task automatic pulse_reset();
      @(posedge clk); #2;
      reset = 1'b1; s_valid = 0; s_finish = 0; s_ready = 0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
   endtask

   task automatic random_accum(int n);
      for (int k = 0; k < n; k++) begin
         int d = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, 255);
         drive($urandom_range(0, 9) < 7, d, $urandom_range(0, 127), $urandom_range(0, 127), 0, 0);
      end
   endtask

   task automatic wait_done(string name);
      for (int k = 0; k < 2000 && !bw.hist_done; k++)
         drive($urandom_range(0, 9) == 0, 0, 4, 4, 0, $urandom_range(0, 2) != 0);
      cmp(name, int'(bw.hist_done), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      clear_caps();
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;

      // Run 1: fixed samples, border filter, saturation, coincident + late sample, stalls
      drive(1, 8'h00, 1, 1, 0, 0);
      drive(1, 8'h00, 1, 2, 0, 0);
      drive(1, 8'hFF, 5, 9, 0, 0);
      drive(1, 8'h10, 0, 5, 0, 0);
      drive(1, 8'h10, 7, 127, 0, 0);
      drive(1, 8'h10, 3, 3, 0, 0);
      for (int k = 0; k < 20; k++) drive(1, 8'h11, 20, 30, 0, 0);
      drive(1, 8'h22, 2, 2, 1, 0);
      drive(1, 8'h22, 2, 2, 0, 1);
      drive(0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 600 && !bw.hist_done; k++) drive(0, 0, 0, 0, 0, 1);
      cmp("run1_done", int'(bw.hist_done), 1);
      drive(0, 0, 0, 0, 0, 1);
      cmp("run1_beats", beats, NUM_BINS);
      cmp("run1_late", int'(bw.late_err), 1);
`ifdef LBP_HIST_UNIFORM_EN
      cmp("pin_map_00", model_bin(8'h00), 0);
      cmp("pin_map_01", model_bin(8'h01), 1);
      cmp("pin_map_55", model_bin(8'h55), 58);
      cmp("pin_map_ff", model_bin(8'hFF), 57);
      cmp("run1_bin0",   cap_w[0], 2);
      cmp("run1_bin57",  cap_w[57], 1);
      cmp("run1_bin58w", cap_w[58], 21);
      cmp("run1_bin58n", cap_n[58], 15);
`else
      cmp("run1_bin0",    cap_w[0], 2);
      cmp("run1_bin255",  cap_w[255], 1);
      cmp("run1_bin16",   cap_w[16], 1);
      cmp("run1_bin17w",  cap_w[17], 20);
      cmp("run1_bin17n",  cap_n[17], 15);
      cmp("run1_bin34",   cap_w[34], 1);
      begin
         int others = 0;
         for (int b = 0; b < 256; b++)
            if (!(b inside {0, 16, 17, 34, 255}) && cap_w[b] != 0) others++;
         cmp("run1_other_bins_nonzero", others, 0);
      end
`endif

      // Run 2: random accumulation, random back-pressure, reset at beat 100
      pulse_reset();
      clear_caps();
      random_accum(300);
      drive(0, 0, 0, 0, 1, 0);
      for (int k = 0; k < 2000 && beats < 100; k++)
         drive($urandom_range(0, 3) == 0, $urandom_range(0, 255), 9, 9, 0, $urandom_range(0, 2) != 0);
      cmp("run2_reached_beat100", int'(beats >= 100), 1);
      @(posedge clk); #2;
      reset = 1'b1; s_valid = 0; s_finish = 0; s_ready = 0;
      @(negedge clk);
      cmp("mid_rst_valid", int'(bw.hist_valid), 0);
      cmp("mid_rst_done",  int'(bw.hist_done), 0);
      cmp("mid_rst_late",  int'(bw.late_err), 0);
      cmp("mid_rst_bin",   int'(bw.hist_bin), 0);
      @(posedge clk); #2 reset = 1'b0;

      // Run 3: bins must start clean after the mid-drain reset
      clear_caps();
      drive(1, 8'h00, 1, 1, 0, 0);
      drive(1, 8'h01, 2, 2, 0, 0);
      drive(1, 8'h55, 3, 3, 0, 0);
      random_accum(200);
      drive(0, 0, 0, 0, 1, 0);
      wait_done("run3_done");
      cmp("run3_beats", beats, NUM_BINS);

      repeat (3) drive(0, 0, 0, 0, 0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
